factorial_engine_p: RTL and testbench

- Parametrised bus-slave factorial accelerator, successor to the fixed 32/64-bit factorial top.
- Host pushes operands N into an input FIFO over the S_* register bus and sets OP_START.
- Engine computes N! per operand with a shift-add sequential multiplier, saturating on overflow, and pushes each result as RES_W/DATA_W words (MS word first) into a result FIFO.
- Raises op_done, plus an interrupt if enabled, when the input FIFO drains.

---
 rtl/fact_pkg.sv | 24 ++
 rtl/sync_fifo_p.sv | 47 ++++
 rtl/factorial_engine_p.sv | 166 ++++++++++++++++
 tb/tb_factorial_engine_p.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// fact_pkg: shared FSM states, register offsets and flag bit positions for the factorial engine
package fact_pkg;
  typedef enum logic [2:0] {IDLE, POP, INIT, MUL, PUSH, DONE} state_t;
  localparam logic [3:0] A_OP_CLEAR = 4'h0;
  localparam logic [3:0] A_INTR_EN  = 4'h1;
  localparam logic [3:0] A_OP_START = 4'h2;
  localparam logic [3:0] A_N_PUSH   = 4'h3;
  localparam logic [3:0] A_R_POP    = 4'h4;
  localparam logic [3:0] A_N_COUNT  = 4'h5;
  localparam logic [3:0] A_N_FLAGS  = 4'h6;
  localparam logic [3:0] A_R_COUNT  = 4'h7;
  localparam logic [3:0] A_R_FLAGS  = 4'h8;
  localparam logic [3:0] A_STATUS   = 4'h9;
  localparam logic [3:0] A_CYCLES   = 4'hA;
  localparam int NF_WR_ERR = 0;
  localparam int NF_FULL   = 1;
  localparam int NF_EMPTY  = 2;
  localparam int RF_OVF    = 0;
  localparam int RF_RD_ERR = 1;
  localparam int RF_FULL   = 2;
  localparam int RF_EMPTY  = 3;
  localparam int ST_DONE   = 0;
  localparam int ST_BUSY   = 1;
endpackage

// File: rtl/sync_fifo_p.sv
// sync_fifo_p: synchronous FIFO with occupancy count, sticky overflow/underflow errors and flush
module sync_fifo_p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             wr_err,
  output logic             rd_err
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  // storage array, written on accepted pushes only
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
      wr_err <= wr_err | (push & full);
      rd_err <= rd_err | (pop & empty);
    end
  end
endmodule

// File: rtl/factorial_engine_p.sv
// factorial_engine_p: bus-slave N! accelerator with operand/result FIFOs; FACT_CYCLE_COUNT_EN adds a busy-cycle counter at 0xA
module factorial_engine_p
  import fact_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RES_W   = 64,
  parameter int N_W     = 6,
  parameter int N_DEPTH = 8,
  parameter int R_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [7:0]        S_address,
  input  logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] S_dout,
  output logic              interrupt,
  output logic              busy
);
  localparam int WORDS = RES_W / DATA_W;
  localparam int PW = RES_W + N_W;
  localparam int CW = $clog2(N_W + 1);
  localparam int XW = $clog2(WORDS + 1);
  localparam int NCW = $clog2(N_DEPTH) + 1;
  localparam int RCW = $clog2(R_DEPTH) + 1;
  state_t state;
  logic wr, rd, clear, start, n_push, r_push, r_pop, room, last;
  logic [3:0] addr;
  logic [N_W-1:0] n_dout, k, mplier;
  logic [NCW-1:0] n_count;
  logic n_empty, n_full, n_wr_err, n_rd_err;
  logic [DATA_W-1:0] r_dout;
  logic [RCW-1:0] r_count;
  logic r_empty, r_full, r_wr_err, r_rd_err;
  logic [RES_W-1:0] acc;
  logic [PW-1:0] prod, mcand;
  logic [CW-1:0] cnt;
  logic [XW-1:0] widx;
  logic op_done, ovf, intr_en;
  logic [2:0] n_flags;
  logic [3:0] r_flags;
  logic [1:0] status;
  logic unused;
  assign addr = S_address[3:0];
  assign wr = S_sel & S_wr;
  assign rd = S_sel & ~S_wr;
  assign clear = wr && addr == A_OP_CLEAR && S_din[0];
  assign start = wr && addr == A_OP_START && S_din[0] && state == IDLE && !n_empty;
  assign n_push = wr && addr == A_N_PUSH && state == IDLE;
  assign r_pop = rd && addr == A_R_POP;
  assign room = r_count <= RCW'(R_DEPTH - WORDS);
  assign r_push = state == PUSH && (widx != '0 || room);
  assign last = widx == XW'(WORDS - 1);
  assign busy = state != IDLE && state != DONE;
  assign unused = ^{S_address[7:4], S_din[DATA_W-1:N_W], n_rd_err, r_wr_err};
  sync_fifo_p #(.WIDTH(N_W), .DEPTH(N_DEPTH)) n_fifo (
    .clk(clk), .reset(reset), .flush(clear), .push(n_push), .pop(state == POP),
    .din(S_din[N_W-1:0]), .dout(n_dout), .count(n_count), .empty(n_empty),
    .full(n_full), .wr_err(n_wr_err), .rd_err(n_rd_err)
  );
  sync_fifo_p #(.WIDTH(DATA_W), .DEPTH(R_DEPTH)) r_fifo (
    .clk(clk), .reset(reset), .flush(clear), .push(r_push), .pop(r_pop),
    .din(acc[RES_W-1 -: DATA_W]), .dout(r_dout), .count(r_count), .empty(r_empty),
    .full(r_full), .wr_err(r_wr_err), .rd_err(r_rd_err)
  );
  // control FSM and shift-add multiplier; the commit cycle checks the product's upper N_W bits for overflow
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      op_done <= 1'b0;
      ovf <= 1'b0;
      intr_en <= 1'b0;
      interrupt <= 1'b0;
      widx <= '0;
    end else begin
      interrupt <= intr_en & op_done;
      if (wr && addr == A_INTR_EN) intr_en <= S_din[0];
      case (state)
        IDLE: state <= start ? POP : IDLE;
        POP: begin
          k <= n_dout;
          state <= INIT;
        end
        INIT: begin
          acc <= RES_W'(1);
          prod <= '0;
          mcand <= PW'(1);
          mplier <= k;
          cnt <= '0;
          state <= k < N_W'(2) ? PUSH : MUL;
        end
        MUL: begin
          if (cnt != CW'(N_W)) begin
            prod <= prod + (mplier[0] ? mcand : '0);
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
          end else if (|prod[PW-1:RES_W]) begin
            acc <= '1;
            ovf <= 1'b1;
            state <= PUSH;
          end else begin
            acc <= prod[RES_W-1:0];
            k <= k - 1'b1;
            prod <= '0;
            mcand <= {{N_W{1'b0}}, prod[RES_W-1:0]};
            mplier <= k - 1'b1;
            cnt <= '0;
            state <= k == N_W'(2) ? PUSH : MUL;
          end
        end
        PUSH: begin
          if (r_push) begin
            acc <= acc << DATA_W;
            widx <= last ? '0 : widx + 1'b1;
            if (last) begin
              state <= n_empty ? DONE : POP;
              op_done <= n_empty;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end
`ifdef FACT_CYCLE_COUNT_EN
  logic [DATA_W-1:0] cycles;
  // saturating count of cycles spent working, restarted by each accepted start
  always_ff @(posedge clk)
    cycles <= (reset || clear || start) ? '0 : (busy && cycles != '1) ? cycles + 1'b1 : cycles;
`endif
  // flag words assembled at their register bit positions
  always_comb begin
    n_flags = '0;
    r_flags = '0;
    status = '0;
    n_flags[NF_EMPTY] = n_empty;
    n_flags[NF_FULL] = n_full;
    n_flags[NF_WR_ERR] = n_wr_err;
    r_flags[RF_EMPTY] = r_empty;
    r_flags[RF_FULL] = r_full;
    r_flags[RF_RD_ERR] = r_rd_err;
    r_flags[RF_OVF] = ovf;
    status[ST_BUSY] = busy;
    status[ST_DONE] = op_done;
  end
  // combinational read mux; nothing is driven unless a read is in progress
  always_comb begin
    S_dout = '0;
    if (rd)
      case (addr)
        A_INTR_EN: S_dout = DATA_W'(intr_en);
        A_R_POP:   S_dout = r_empty ? '0 : r_dout;
        A_N_COUNT: S_dout = DATA_W'(n_count);
        A_N_FLAGS: S_dout = DATA_W'(n_flags);
        A_R_COUNT: S_dout = DATA_W'(r_count);
        A_R_FLAGS: S_dout = DATA_W'(r_flags);
        A_STATUS:  S_dout = DATA_W'(status);
`ifdef FACT_CYCLE_COUNT_EN
        A_CYCLES:  S_dout = cycles;
`endif
        default:   S_dout = '0;
      endcase
  end
endmodule

// File: tb/tb_factorial_engine_p.sv
// tb_factorial_engine_p: directed self-checking bench for factorial_engine_p (result FIFO shrunk to 4 words)
module tb_factorial_engine_p;
  import fact_pkg::*;
  logic clk = 1'b0;
  logic reset, S_sel, S_wr, interrupt, busy;
  logic [7:0] S_address;
  logic [31:0] S_din, S_dout, d;
  int vectors = 0;
  int errors = 0;

  factorial_engine_p #(.DATA_W(32), .RES_W(64), .N_W(6), .N_DEPTH(8), .R_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .S_dout(S_dout), .interrupt(interrupt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    S_sel = 1'b1; S_wr = 1'b1; S_address = {4'h0, a}; S_din = v;
    @(negedge clk);
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    S_sel = 1'b1; S_wr = 1'b0; S_address = {4'h0, a};
    #1 v = S_dout;
    @(negedge clk);
    S_sel = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk("idle_wait", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_dout", S_dout, 32'd0);
    chk("rst_irq", {31'b0, interrupt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk_rd("rst_status", A_STATUS, 32'd0);
    chk_rd("rst_nflags", A_N_FLAGS, 32'h4);
    chk_rd("rst_rflags", A_R_FLAGS, 32'h8);
    chk_rd("rst_intr_en", A_INTR_EN, 32'd0);
    chk_rd("unmapped", 4'hB, 32'd0);

    wr(A_N_PUSH, 32'd5);
    chk_rd("n_count1", A_N_COUNT, 32'd1);
    wr(A_OP_START, 32'd1);
    chk("busy_run", {31'b0, busy}, 32'd1);
    wait_idle(200);
    chk_rd("f5_status", A_STATUS, 32'd1);
    chk_rd("f5_rcount", A_R_COUNT, 32'd2);
`ifdef FACT_CYCLE_COUNT_EN
    chk_rd("f5_cycles", A_CYCLES, 32'd32);
`else
    chk_rd("f5_cycles_off", A_CYCLES, 32'd0);
`endif
    chk_rd("f5_hi", A_R_POP, 32'h0000_0000);
    chk_rd("f5_lo", A_R_POP, 32'h0000_0078);
    chk_rd("f5_rcount0", A_R_COUNT, 32'd0);
    wr(A_OP_CLEAR, 32'd1);

    wr(A_N_PUSH, 32'hFFFF_FFD4);
    wr(A_N_PUSH, 32'd21);
    wr(A_OP_START, 32'd1);
    wait_idle(1000);
    chk_rd("f20_rcount", A_R_COUNT, 32'd4);
    chk_rd("f20_rflags", A_R_FLAGS, 32'h5);
    chk_rd("f20_hi", A_R_POP, 32'h21C3_677C);
    chk_rd("f20_lo", A_R_POP, 32'h82B4_0000);
    chk_rd("f21_hi", A_R_POP, 32'hFFFF_FFFF);
    chk_rd("f21_lo", A_R_POP, 32'hFFFF_FFFF);
    wr(A_OP_CLEAR, 32'd1);
    chk_rd("clr_rflags", A_R_FLAGS, 32'h8);

    wr(A_INTR_EN, 32'd1);
    chk_rd("intr_en_set", A_INTR_EN, 32'd1);
    wr(A_N_PUSH, 32'd0);
    wr(A_N_PUSH, 32'd1);
    wr(A_OP_START, 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("f01_done", {31'b0, busy}, 32'd0);
    chk("irq_lag", {31'b0, interrupt}, 32'd0);
    @(negedge clk);
    chk("irq_high", {31'b0, interrupt}, 32'd1);
    chk_rd("f0_hi", A_R_POP, 32'd0);
    chk_rd("f0_lo", A_R_POP, 32'd1);
    chk_rd("f1_hi", A_R_POP, 32'd0);
    chk_rd("f1_lo", A_R_POP, 32'd1);
    chk_rd("f01_status", A_STATUS, 32'd1);
    wr(A_OP_CLEAR, 32'd1);
    chk("irq_clr", {31'b0, interrupt}, 32'd0);
    chk_rd("intr_en_clr", A_INTR_EN, 32'd0);

    for (int i = 0; i < 9; i++) wr(A_N_PUSH, 32'd2);
    chk_rd("nfull_count", A_N_COUNT, 32'd8);
    chk_rd("nfull_flags", A_N_FLAGS, 32'h3);
    chk_rd("rpop_empty", A_R_POP, 32'd0);
    chk_rd("rd_err_flags", A_R_FLAGS, 32'hA);
    wr(A_OP_CLEAR, 32'd1);
    chk_rd("nclr_flags", A_N_FLAGS, 32'h4);
    chk_rd("nclr_count", A_N_COUNT, 32'd0);

    for (int i = 0; i < 8; i++) wr(A_N_PUSH, 32'd3);
    wr(A_OP_START, 32'd1);
    repeat (200) @(negedge clk);
    chk("stall_busy", {31'b0, busy}, 32'd1);
    chk_rd("stall_rcount", A_R_COUNT, 32'd4);
    chk_rd("stall_ncount", A_N_COUNT, 32'd5);
    for (int w = 0; w < 16; w++) begin
      d = '0;
      for (int t = 0; t < 100 && d == 0; t++) rd(A_R_COUNT, d);
      chk("stall_wait", {31'b0, d != 0}, 32'd1);
      chk_rd((w % 2) ? "f3_lo" : "f3_hi", A_R_POP, (w % 2) ? 32'd6 : 32'd0);
    end
    wait_idle(200);
    chk_rd("f3_status", A_STATUS, 32'd1);
    chk_rd("f3_rflags", A_R_FLAGS, 32'h8);
    wr(A_OP_CLEAR, 32'd1);

    wr(A_N_PUSH, 32'd12);
    wr(A_OP_START, 32'd1);
    repeat (30) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    wr(A_OP_CLEAR, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk_rd("abort_ncount", A_N_COUNT, 32'd0);
    chk_rd("abort_rcount", A_R_COUNT, 32'd0);
    chk_rd("abort_status", A_STATUS, 32'd0);
    chk_rd("abort_nflags", A_N_FLAGS, 32'h4);
    chk_rd("abort_rflags", A_R_FLAGS, 32'h8);

    wr(A_N_PUSH, 32'd4);
    wr(A_OP_START, 32'd1);
    wait_idle(200);
    chk_rd("f4_hi", A_R_POP, 32'd0);
    chk_rd("f4_lo", A_R_POP, 32'h18);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
